// File: rtl/seq_serializer_if.sv
// Word-load handshake and serial output bundle for seq_serializer.
// The producer drives Data_in/Load_valid (master); the serializer drives the rest (slave).
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Data_in;
    logic             Load_valid;
    logic             Load_ready;
    logic             Dout;
    logic             Dout_valid;
    logic             Busy;

    modport master (
        output Data_in, Load_valid,
        input  Load_ready, Dout, Dout_valid, Busy
    );

    modport slave (
        input  Data_in, Load_valid,
        output Load_ready, Dout, Dout_valid, Busy
    );
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial stage feeding a sequence detector.
// Accepts WIDTH-bit words and streams them one bit per clock on Dout, with
// back-to-back words streaming gap-free and an idle line held at 0.
// Optional build macro: LSB_FIRST_EN (emit Data_in[0] first instead of MSB first).
//
// Handshake: a word is accepted on a rising Clk edge where Load_valid and
// Load_ready are both high. Load_ready is combinational and is high in IDLE and
// while the last bit of the current word is on Dout. Load_valid while
// Load_ready is low is ignored; the producer holds Data_in until accepted.
module seq_serializer #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    seq_serializer_if.slave    bus,
    output logic               dbg_state
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             dout_q;
    logic             dout_valid_q;

    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic [WIDTH-1:0] load_rest;
    logic             next_bit;
    logic [WIDTH-1:0] shift_rest;

    assign last_bit       = (state == SHIFT) && (cnt == LAST);
    assign bus.Load_ready = (state == IDLE) || last_bit;
    assign accept         = bus.Load_valid && bus.Load_ready;

    // The first bit goes straight to Dout on load; shreg holds the bits still to come.
`ifdef LSB_FIRST_EN
    assign first_bit  = bus.Data_in[0];
    assign load_rest  = bus.Data_in >> 1;
    assign next_bit   = shreg[0];
    assign shift_rest = shreg >> 1;
`else
    assign first_bit  = bus.Data_in[WIDTH-1];
    assign load_rest  = bus.Data_in << 1;
    assign next_bit   = shreg[WIDTH-1];
    assign shift_rest = shreg << 1;
`endif

    // Serializer FSM with registered Dout/Dout_valid; reload on the last bit keeps streaming gap-free.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHIFT;
                        shreg        <= load_rest;
                        cnt          <= '0;
                        dout_q       <= first_bit;
                        dout_valid_q <= 1'b1;
                    end else begin
                        dout_q       <= 1'b0;
                        dout_valid_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        if (accept) begin
                            shreg        <= load_rest;
                            cnt          <= '0;
                            dout_q       <= first_bit;
                            dout_valid_q <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            shreg        <= '0;
                            cnt          <= '0;
                            dout_q       <= 1'b0;
                            dout_valid_q <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        shreg  <= shift_rest;
                        dout_q <= next_bit;
                    end
                end
                default: begin
                    state        <= IDLE;
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Dout       = dout_q;
    assign bus.Dout_valid = dout_valid_q;
    assign bus.Busy       = dout_valid_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_seq_serializer.sv
// Directed testbench for seq_serializer (WIDTH=8, Clk period 20, checks at negedge).
// Honors LSB_FIRST_EN for the expected bit sequences.
module tb_seq_serializer;
    logic Clk;
    logic Rst;
    logic dbg_state;
    int   n_cmp;
    int   n_err;

    seq_serializer_if #(.WIDTH(8)) bus ();

    seq_serializer #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Expected serial sequences, first emitted bit in the MSB of each constant.
`ifdef LSB_FIRST_EN
    localparam logic [7:0]  EXP_C1 = 8'b1000_0011;
    localparam logic [15:0] EXP_55_AA = 16'b1010_1010_0101_0101;
    localparam logic [7:0]  EXP_F0 = 8'b0000_1111;
`else
    localparam logic [7:0]  EXP_C1 = 8'b1100_0001;
    localparam logic [15:0] EXP_55_AA = 16'b0101_0101_1010_1010;
    localparam logic [7:0]  EXP_F0 = 8'b1111_0000;
`endif
    localparam logic [7:0]  EXP_81 = 8'b1000_0001;

    task automatic test_reset();
        Rst = 1'b1;
        bus.Load_valid = 1'b0;
        bus.Data_in = 8'h00;
        @(negedge Clk);
        n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL rst_dout: got %b want 0", bus.Dout); end
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.Dout_valid); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
        n_cmp++; if (bus.Load_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.Load_ready); end
        n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b want 0", dbg_state); end
        #10 Rst = 1'b0;
        @(negedge Clk);
        n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL post_rst_dout: got %b want 0", bus.Dout); end
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b want 0", bus.Dout_valid); end
        n_cmp++; if (bus.Load_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", bus.Load_ready); end
    endtask

    // Single word: accepted at edge k, bits on k+1..k+8, idle at k+9.
    // Data_in is scrambled after accept to show the word in flight is unaffected.
    task automatic test_single(input logic [7:0] word, input logic [7:0] exp_bits, input string tag);
        @(negedge Clk);
        bus.Data_in = word;
        bus.Load_valid = 1'b1;
        n_cmp++; if (bus.Load_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_idle: got %b want 1", tag, bus.Load_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                bus.Load_valid = 1'b0;
                bus.Data_in = ~word;
            end
            n_cmp++; if (bus.Dout !== exp_bits[7-i]) begin n_err++; $display("FAIL %s_bit%0d: got %b want %b", tag, i, bus.Dout, exp_bits[7-i]); end
            n_cmp++; if (bus.Dout_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid%0d: got %b want 1", tag, i, bus.Dout_valid); end
            n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL %s_busy%0d: got %b want 1", tag, i, bus.Busy); end
            n_cmp++; if (bus.Load_ready !== (i == 7)) begin n_err++; $display("FAIL %s_ready%0d: got %b want %b", tag, i, bus.Load_ready, (i == 7)); end
        end
        @(negedge Clk);
        n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL %s_idle_dout: got %b want 0", tag, bus.Dout); end
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle_valid: got %b want 0", tag, bus.Dout_valid); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL %s_idle_busy: got %b want 0", tag, bus.Busy); end
        n_cmp++; if (bus.Load_ready !== 1'b1) begin n_err++; $display("FAIL %s_idle_ready: got %b want 1", tag, bus.Load_ready); end
    endtask

    // Two words with Load_valid held high: 16 contiguous valid bits.
    task automatic test_back_to_back();
        @(negedge Clk);
        bus.Data_in = 8'h55;
        bus.Load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            if (i == 0) bus.Data_in = 8'hAA;
            if (i == 8) bus.Load_valid = 1'b0;
            n_cmp++; if (bus.Dout !== EXP_55_AA[15-i]) begin n_err++; $display("FAIL b2b_bit%0d: got %b want %b", i, bus.Dout, EXP_55_AA[15-i]); end
            n_cmp++; if (bus.Dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b want 1", i, bus.Dout_valid); end
            n_cmp++; if (bus.Load_ready !== (i == 7 || i == 15)) begin n_err++; $display("FAIL b2b_ready%0d: got %b want %b", i, bus.Load_ready, (i == 7 || i == 15)); end
        end
        @(negedge Clk);
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", bus.Dout_valid); end
        n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL b2b_idle_dout: got %b want 0", bus.Dout); end
    endtask

    // Load_valid pulse with 8'hFF while bit 3 of 8'h00 is on the line must be ignored.
    task automatic test_ignore_busy();
        @(negedge Clk);
        bus.Data_in = 8'h00;
        bus.Load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (i == 0) bus.Load_valid = 1'b0;
            n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL ign_bit%0d: got %b want 0", i, bus.Dout); end
            n_cmp++; if (bus.Dout_valid !== 1'b1) begin n_err++; $display("FAIL ign_valid%0d: got %b want 1", i, bus.Dout_valid); end
            if (i == 3) begin
                bus.Data_in = 8'hFF;
                bus.Load_valid = 1'b1;
                n_cmp++; if (bus.Load_ready !== 1'b0) begin n_err++; $display("FAIL ign_ready_pulse: got %b want 0", bus.Load_ready); end
            end
            if (i == 4) bus.Load_valid = 1'b0;
        end
        @(negedge Clk);
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL ign_idle_valid: got %b want 0", bus.Dout_valid); end
        n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL ign_idle_dout: got %b want 0", bus.Dout); end
    endtask

    // Asynchronous reset between edges at bit 4 of 8'hF0, then a fresh word.
    task automatic test_reset_mid_word();
        @(negedge Clk);
        bus.Data_in = 8'hF0;
        bus.Load_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i == 0) bus.Load_valid = 1'b0;
            n_cmp++; if (bus.Dout !== EXP_F0[7-i]) begin n_err++; $display("FAIL mid_bit%0d: got %b want %b", i, bus.Dout, EXP_F0[7-i]); end
        end
        #5 Rst = 1'b1;
        #1;
        n_cmp++; if (bus.Dout !== 1'b0) begin n_err++; $display("FAIL mid_rst_dout: got %b want 0", bus.Dout); end
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.Dout_valid); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", bus.Busy); end
        #2 Rst = 1'b0;
        @(negedge Clk);
        n_cmp++; if (bus.Dout_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_valid: got %b want 0", bus.Dout_valid); end
        n_cmp++; if (bus.Load_ready !== 1'b1) begin n_err++; $display("FAIL mid_after_ready: got %b want 1", bus.Load_ready); end
        test_single(8'h81, EXP_81, "w81");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single(8'hC1, EXP_C1, "wc1");
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
